seq_detect_sched: RTL and testbench

Round-robin scheduler that shares one serial 1011 pattern detector among NUM_REQ requesters. Each requester offers a FRAME_LEN-bit frame. The scheduler grants one frame at a time, clears the detector, and shifts the frame in LSB-first, one bit per cycle. It counts detections, records the bit index of the first detection, and returns a tagged result over a valid/ready handshake. It sits between the frame producers and the downstream consumer of match statistics.

---
 rtl/seq_detect_pkg.sv | 23 ++
 rtl/seq_detect_core.sv | 46 ++++
 rtl/seq_detect_sched.sv | 153 +++++++++++++++
 tb/tb_seq_detect_sched.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg
//   Shared state encodings for the pattern detector core and the
//   round-robin scheduler that feeds it.
//   det_state_t : serial 1011 detector states (3 bits)
//   sch_state_t : scheduler states (2 bits)
package seq_detect_pkg;

    typedef enum logic [2:0] {
        DET_IDLE  = 3'd0,
        DET_S1    = 3'd1,
        DET_S10   = 3'd2,
        DET_S101  = 3'd3,
        DET_S1011 = 3'd4
    } det_state_t;

    typedef enum logic [1:0] {
        SCH_IDLE  = 2'd0,
        SCH_SHIFT = 2'd1,
        SCH_DRAIN = 2'd2,
        SCH_DONE  = 2'd3
    } sch_state_t;

endpackage

// File: rtl/seq_detect_core.sv
// seq_detect_core
//   Serial overlapping 1011 detector. One bit is consumed per clock;
//   seq_seen is registered, so it reflects the bit consumed on the
//   previous edge.
//   clk      : clock, posedge
//   reset_n  : synchronous active-low reset
//   clr      : synchronous clear back to DET_IDLE
//   in_bit   : serial input bit
//   seq_seen : high while the last four bits were 1,0,1,1
module seq_detect_core
    import seq_detect_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic in_bit,
    output logic seq_seen
);

    det_state_t r_state;
    det_state_t w_next;

    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            r_state <= DET_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            DET_IDLE:  w_next = in_bit ? DET_S1    : DET_IDLE;
            DET_S1:    w_next = in_bit ? DET_S1    : DET_S10;
            DET_S10:   w_next = in_bit ? DET_S101  : DET_IDLE;
            DET_S101:  w_next = in_bit ? DET_S1011 : DET_S10;
            // overlap: trailing "1" or "10" seeds the next match
            DET_S1011: w_next = in_bit ? DET_S1    : DET_S10;
            default:   w_next = DET_IDLE;
        endcase
    end

    assign seq_seen = (r_state == DET_S1011);

endmodule

// File: rtl/seq_detect_sched.sv
// seq_detect_sched
//   Round-robin scheduler sharing one serial 1011 detector among NUM_REQ
//   requesters. A granted frame is shifted LSB-first through the detector;
//   the number of detections and the bit index that completed the first
//   one are returned with the owner's ID over a valid/ready handshake.
//   clk        : clock, posedge
//   reset_n    : synchronous active-low reset
//   req_valid  : per-requester frame offer
//   req_data   : frames, requester i at [i*FRAME_LEN +: FRAME_LEN]
//   req_ready  : one-hot single-cycle acceptance pulse
//   res_valid  : result available (DONE)
//   res_ready  : consumer accepts result
//   res_id     : owner of the frame
//   res_count  : detections in the frame
//   res_first  : bit index completing the first detection, FRAME_LEN if none
//   busy       : scheduler not idle
module seq_detect_sched
    import seq_detect_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int FRAME_LEN = 16,
    parameter int CW        = $clog2(FRAME_LEN + 1),
    parameter int IDW       = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*FRAME_LEN-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [IDW-1:0]                 res_id,
    output logic [CW-1:0]                  res_count,
    output logic [CW-1:0]                  res_first,
    output logic                           busy
);

    sch_state_t           r_state;
    sch_state_t           w_next;
    logic [IDW-1:0]       r_ptr;
    logic [IDW-1:0]       r_id;
    logic [FRAME_LEN-1:0] r_shift;
    logic [CW-1:0]        r_bitcnt;
    logic [CW-1:0]        r_count;
    logic [CW-1:0]        r_first;

    logic                 w_any;
    logic                 w_accept;
    logic [IDW-1:0]       w_gnt;
    logic [IDW-1:0]       w_idx;
    int                   w_cand;
    logic                 w_seen;
    logic                 w_hit;
    logic [CW-1:0]        w_hit_idx;

    // Round-robin pick: first valid at or after the pointer, wrapping.
    always_comb begin
        w_any  = 1'b0;
        w_gnt  = '0;
        w_idx  = '0;
        w_cand = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = int'(r_ptr) + i;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            w_idx = IDW'(w_cand);
            if (!w_any && req_valid[w_idx]) begin
                w_any = 1'b1;
                w_gnt = w_idx;
            end
        end
    end

    // Gated by reset_n so nothing is accepted on a reset edge.
    assign w_accept  = (r_state == SCH_IDLE) && w_any && reset_n;
    assign req_ready = w_accept ? (NUM_REQ'(1) << w_gnt) : '0;

    seq_detect_core u_core (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (w_accept),
        .in_bit   (r_shift[0]),
        .seq_seen (w_seen)
    );

    // seq_seen lags the fed bit by one cycle: in SHIFT cycle k it reports
    // bit k-1, and DRAIN exists only to observe the final bit.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = r_bitcnt - CW'(1);
        case (r_state)
            SCH_SHIFT: w_hit = w_seen && (r_bitcnt != '0);
            SCH_DRAIN: begin
                w_hit     = w_seen;
                w_hit_idx = CW'(FRAME_LEN - 1);
            end
            default: ;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            SCH_IDLE:  if (w_accept) w_next = SCH_SHIFT;
            SCH_SHIFT: if (r_bitcnt == CW'(FRAME_LEN - 1)) w_next = SCH_DRAIN;
            SCH_DRAIN: w_next = SCH_DONE;
            SCH_DONE:  if (res_ready) w_next = SCH_IDLE;
            default:   w_next = SCH_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= SCH_IDLE;
            r_ptr    <= '0;
            r_id     <= '0;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_count  <= '0;
            r_first  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_shift  <= req_data[int'(w_gnt)*FRAME_LEN +: FRAME_LEN];
                r_id     <= w_gnt;
                r_bitcnt <= '0;
                r_count  <= '0;
                r_first  <= CW'(FRAME_LEN);
                r_ptr    <= (int'(w_gnt) == NUM_REQ - 1) ? '0 : w_gnt + 1'b1;
            end
            if (r_state == SCH_SHIFT) begin
                r_shift  <= r_shift >> 1;
                r_bitcnt <= r_bitcnt + CW'(1);
            end
            if (w_hit) begin
                if (r_count != {CW{1'b1}}) begin
                    r_count <= r_count + CW'(1);
                end
                if (r_first == CW'(FRAME_LEN)) begin
                    r_first <= w_hit_idx;
                end
            end
        end
    end

    assign res_valid = (r_state == SCH_DONE);
    assign busy      = (r_state != SCH_IDLE);
    assign res_id    = r_id;
    assign res_count = r_count;
    assign res_first = r_first;

endmodule

// File: tb/tb_seq_detect_sched.sv
module tb_seq_detect_sched;

    localparam int N   = 4;
    localparam int FL  = 16;
    localparam int CW  = 5;
    localparam int IDW = 2;

    logic              clk;
    logic              reset_n;
    logic [N-1:0]      r_v;
    logic [N*FL-1:0]   pk_data;
    logic [N-1:0]      req_ready;
    logic              res_valid;
    logic              res_ready;
    logic [IDW-1:0]    res_id;
    logic [CW-1:0]     res_count;
    logic [CW-1:0]     res_first;
    logic              busy;

    seq_detect_sched #(.NUM_REQ(N), .FRAME_LEN(FL)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (r_v),
        .req_data  (pk_data),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_count (res_count),
        .res_first (res_first),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [FL-1:0] r_d [N];
    logic [N-1:0]  granted;
    int p_req, p_rdy;

    // reference model state
    bit m_inflight;
    int m_age, m_ptr, m_id, m_cnt, m_first;
    int cyc, acc_cyc, rise_cyc, hs_cyc, hs_cnt;
    int l_id, l_count, l_first;
    int g_log[$];
    int n0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // A detection completes at bit j when bits j-3..j arrived as 1,0,1,1
    // (LSB-first), overlaps allowed.
    function automatic void ref_frame(input logic [FL-1:0] d, output int cnt, output int first);
        cnt = 0;
        first = FL;
        for (int j = 3; j < FL; j++) begin
            if (d[j-3] && !d[j-2] && d[j-1] && d[j]) begin
                cnt++;
                if (first == FL) first = j;
            end
        end
    endfunction

    task automatic pack();
        for (int i = 0; i < N; i++) pk_data[i*FL +: FL] = r_d[i];
    endtask

    // One clock: check outputs mid-cycle against the model, advance the
    // model across the edge, then drive the next inputs.
    task automatic cycle();
        int g;
        logic [N-1:0] exp_rdy;
        bit exp_rv;
        @(negedge clk);
        g = -1;
        exp_rdy = '0;
        if (!m_inflight) begin
            for (int i = 0; i < N; i++) begin
                if (g < 0 && r_v[(m_ptr + i) % N]) g = (m_ptr + i) % N;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        exp_rv = m_inflight && (m_age >= FL + 2);
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("busy", 32'(busy), 32'(m_inflight));
        chk("res_valid", 32'(res_valid), 32'(exp_rv));
        if (exp_rv) begin
            chk("res_id", 32'(res_id), 32'(m_id));
            chk("res_count", 32'(res_count), 32'(m_cnt));
            chk("res_first", 32'(res_first), 32'(m_first));
        end
        if (req_ready != '0) begin
            acc_cyc = cyc;
            rise_cyc = -1;
        end
        if (res_valid && rise_cyc < 0) rise_cyc = cyc;
        if (g >= 0) begin
            g_log.push_back(g);
            ref_frame(r_d[g], m_cnt, m_first);
            m_id = g;
            m_inflight = 1'b1;
            m_age = 1;
            m_ptr = (g + 1) % N;
            granted[g] = 1'b1;
        end else if (m_inflight) begin
            if (exp_rv && res_ready) begin
                m_inflight = 1'b0;
                hs_cnt++;
                hs_cyc = cyc;
                l_id = int'(res_id);
                l_count = int'(res_count);
                l_first = int'(res_first);
            end else begin
                m_age++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (granted[i]) begin
                r_v[i] = ($urandom_range(99) < p_req);
                r_d[i] = 16'($urandom);
                granted[i] = 1'b0;
            end else if (!r_v[i] && ($urandom_range(99) < p_req)) begin
                r_v[i] = 1'b1;
                r_d[i] = 16'($urandom);
            end
        end
        res_ready = ($urandom_range(99) < p_rdy);
        pack();
    endtask

    task automatic wait_grants(input int n);
        for (int k = 0; k < 400 && g_log.size() < n; k++) cycle();
        chk("grant_wait", 32'(g_log.size()), 32'(n));
    endtask

    task automatic one_frame(input int r, input logic [FL-1:0] d, input int ec, input int ef);
        int h;
        h = hs_cnt;
        r_v = '0;
        r_v[r] = 1'b1;
        r_d[r] = d;
        pack();
        p_req = 0;
        p_rdy = 100;
        res_ready = 1'b1;
        for (int k = 0; k < 60 && hs_cnt == h; k++) cycle();
        chk("frame_done", 32'(hs_cnt), 32'(h + 1));
        chk("frame_id", 32'(l_id), 32'(r));
        chk("frame_count", 32'(l_count), 32'(ec));
        chk("frame_first", 32'(l_first), 32'(ef));
        chk("frame_latency", 32'(rise_cyc - acc_cyc), 32'(FL + 2));
    endtask

    initial begin
        reset_n = 1'b0;
        r_v = '0;
        res_ready = 1'b0;
        granted = '0;
        p_req = 0;
        p_rdy = 0;
        for (int i = 0; i < N; i++) r_d[i] = '0;
        pack();
        m_inflight = 1'b0;
        m_ptr = 0;
        m_age = 0;
        cyc = 0;
        acc_cyc = 0;
        rise_cyc = -1;
        hs_cyc = 0;
        hs_cnt = 0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_id", 32'(res_id), 32'd0);
        chk("rst_res_count", 32'(res_count), 32'd0);
        chk("rst_res_first", 32'(res_first), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // directed frames
        one_frame(0, 16'h006D, 2, 3);
        one_frame(1, 16'hDDDD, 4, 3);
        one_frame(2, 16'h0000, 0, 16);
        one_frame(3, 16'hFFFF, 0, 16);
        // 0xD000 puts 1,0,1,1 on bits 12..15: match completes on the last bit
        one_frame(0, 16'hD000, 1, 15);
        // 0xB000 arrives as 1,1,0,1 on bits 12..15: no match
        one_frame(1, 16'hB000, 0, 16);

        // round-robin with all requesters asserting
        g_log.delete();
        p_req = 100;
        p_rdy = 100;
        res_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            r_v[i] = 1'b1;
            r_d[i] = 16'($urandom);
        end
        pack();
        wait_grants(5);
        chk("rr_g0", 32'(g_log[0]), 32'd2);
        chk("rr_g1", 32'(g_log[1]), 32'd3);
        chk("rr_g2", 32'(g_log[2]), 32'd0);
        chk("rr_g3", 32'(g_log[3]), 32'd1);
        chk("rr_g4", 32'(g_log[4]), 32'd2);
        wait_grants(7);
        // pointer now at 0 after the 0xB000 frame went to req1? no: trace
        // from req1 -> pointer 2, so the order above starts at 2.
        p_req = 0;
        r_v = 4'b1000;
        pack();
        // pointer after 7 grants (2,3,0,1,2,3,0) is 1; only req3 offers
        wait_grants(8);
        chk("rr_only3", 32'(g_log[7]), 32'd3);
        r_v = 4'b0011;
        pack();
        wait_grants(9);
        chk("rr_wrap0", 32'(g_log[8]), 32'd0);

        // backpressure in DONE
        for (int k = 0; k < 60 && m_inflight; k++) cycle();
        p_req = 0;
        p_rdy = 0;
        res_ready = 1'b0;
        r_v = 4'b0010;
        r_d[1] = 16'h006D;
        pack();
        n0 = g_log.size();
        wait_grants(n0 + 1);
        for (int k = 0; k < 40 && rise_cyc < 0; k++) cycle();
        chk("bp_rise", 32'(rise_cyc >= 0), 32'd1);
        r_v[2] = 1'b1;
        r_d[2] = 16'h0B0B;
        pack();
        for (int k = 0; k < 10; k++) cycle();
        chk("bp_held_count", 32'(res_count), 32'd2);
        chk("bp_held_first", 32'(res_first), 32'd3);
        p_rdy = 100;
        res_ready = 1'b1;
        cycle();
        wait_grants(n0 + 2);
        chk("bp_next_accept", 32'(acc_cyc - hs_cyc), 32'd1);

        // reset mid-SHIFT
        for (int k = 0; k < 4; k++) cycle();
        reset_n = 1'b0;
        r_v = '0;
        pack();
        @(negedge clk);
        chk("rst2_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc++;
        m_inflight = 1'b0;
        m_ptr = 0;
        granted = '0;
        @(negedge clk);
        chk("rst2_busy", 32'(busy), 32'd0);
        chk("rst2_res_valid", 32'(res_valid), 32'd0);
        chk("rst2_res_id", 32'(res_id), 32'd0);
        chk("rst2_res_count", 32'(res_count), 32'd0);
        chk("rst2_res_first", 32'(res_first), 32'd0);
        chk("rst2_req_ready_after", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        cyc++;
        r_v = 4'b1100;
        pack();
        n0 = g_log.size();
        wait_grants(n0 + 1);
        chk("rst2_lowest", 32'(g_log[n0]), 32'd2);

        // random traffic against the model
        p_req = 40;
        p_rdy = 60;
        for (int k = 0; k < 1500; k++) cycle();
        p_req = 0;
        p_rdy = 100;
        for (int k = 0; k < 30; k++) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
